bit32_alu: RTL and testbench

Single-cycle 32-bit accumulator-style ALU with two architectural registers (regA, regB), a 64-word local data memory, and IEEE-754 single-precision add/sub/multiply alongside integer, logic, shift and load/store operations. One operation executes per rising clock edge, selected by a 4-bit opcode. The result always lands in the register chosen by `sel`. It serves as a self-contained execution block for small datapath experiments; no pipeline and no handshake.

---
 rtl/bit32_alu_pkg.sv | 49 ++++
 rtl/fp32_unit.sv | 113 +++++++++++
 rtl/bit32_alu.sv | 108 ++++++++++
 tb/tb_bit32_alu.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit32_alu_pkg.sv
// Shared types and constants for the bit32_alu accumulator ALU.
// Opcodes, FP field widths and the byte-lane select type.
package bit32_alu_pkg;

    typedef enum logic [3:0] {
        FADD = 4'b0000,
        FSUB = 4'b0001,
        FMUL = 4'b0010,
        AND  = 4'b0011,
        OR   = 4'b0100,
        STL  = 4'b0101,
        LDD  = 4'b0110,
        ADDI = 4'b0111,
        SLI  = 4'b1000,
        SB   = 4'b1001,
        LB   = 4'b1010,
        LW   = 4'b1011,
        SW   = 4'b1100,
        SLL  = 4'b1101,
        SDD  = 4'b1110,
        SRA  = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        FP_ADD = 2'd0,
        FP_SUB = 2'd1,
        FP_MUL = 2'd2
    } fp_op_e;

    typedef logic [1:0] lane_t;

    localparam int FP_BIAS = 127;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

    // Leading-zero count of a 27-bit value (valid for non-zero input).
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/fp32_unit.sv
// Combinational single-precision add/sub/mul, truncating rounding,
// subnormals flushed to signed zero, canonical NaN on invalid input.
module fp32_unit
    import bit32_alu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  fp_op_e      op_i,
    output logic [31:0] res_o
);

    localparam logic signed [9:0] BiasS = 10'(FP_BIAS);

    logic              sa, sb, sm;
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    assign sa = a_i[31];
    assign sb = b_i[31] ^ (op_i == FP_SUB);
    assign sm = a_i[31] ^ b_i[31];
    assign ea = a_i[30:23];
    assign eb = b_i[30:23];
    assign fa = a_i[22:0];
    assign fb = b_i[22:0];

    assign nan_a  = (ea == EXP_MAX) && (fa != '0);
    assign nan_b  = (eb == EXP_MAX) && (fb != '0);
    assign inf_a  = (ea == EXP_MAX) && (fa == '0);
    assign inf_b  = (eb == EXP_MAX) && (fb == '0);
    assign zero_a = (ea == '0);
    assign zero_b = (eb == '0);

    logic              a_big, big_s;
    logic [7:0]        big_e, sml_e, dexp;
    logic [26:0]       big_x, sml_x, aln, diff, norm;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic signed [9:0] e_add;

    assign a_big = a_i[30:0] >= b_i[30:0];
    assign big_s = a_big ? sa : sb;
    assign big_e = a_big ? ea : eb;
    assign sml_e = a_big ? eb : ea;
    assign big_x = {1'b1, a_big ? fa : fb, 3'b000};
    assign sml_x = {1'b1, a_big ? fb : fa, 3'b000};
    assign dexp  = big_e - sml_e;

    // Guard/round/sticky keep the truncated result exact for subtraction.
    always_comb begin
        aln = 27'd1;
        if (dexp < 8'd27) begin
            aln = (sml_x >> dexp)
                | {26'd0, |(sml_x & ~({27{1'b1}} << dexp))};
        end
        sum   = '0;
        diff  = '0;
        lz    = '0;
        norm  = '0;
        e_add = '0;
        if (sa == sb) begin
            sum   = {1'b0, big_x} + {1'b0, aln};
            norm  = sum[27] ? {sum[27:2], sum[1] | sum[0]} : sum[26:0];
            e_add = $signed({2'b00, big_e}) + $signed({9'd0, sum[27]});
        end else begin
            diff  = big_x - aln;
            lz    = lzc27(diff);
            norm  = diff << lz;
            e_add = $signed({2'b00, big_e}) - $signed({5'd0, lz});
        end
    end

    logic [47:0]       prod;
    logic [22:0]       m_mul;
    logic signed [9:0] e_mul;

    assign prod  = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
    assign m_mul = prod[47] ? prod[46:24] : prod[45:23];
    assign e_mul = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BiasS
                 + $signed({9'd0, prod[47]});

    logic unused_bits;
    assign unused_bits = ^{prod[22:0], norm[2:0]};

    logic [31:0] add_res, mul_res;

    always_comb begin
        if (nan_a || nan_b)       add_res = QNAN;
        else if (inf_a && inf_b)  add_res = (sa == sb) ? {sa, EXP_MAX, 23'd0} : QNAN;
        else if (inf_a)           add_res = {sa, EXP_MAX, 23'd0};
        else if (inf_b)           add_res = {sb, EXP_MAX, 23'd0};
        else if (zero_a && zero_b) add_res = '0;
        else if (zero_a)          add_res = {sb, b_i[30:0]};
        else if (zero_b)          add_res = a_i;
        else if (norm == '0)      add_res = '0;
        else if (e_add >= 10'sd255) add_res = {big_s, EXP_MAX, 23'd0};
        else if (e_add <= 10'sd0) add_res = {big_s, 31'd0};
        else                      add_res = {big_s, e_add[7:0], norm[25:3]};
    end

    always_comb begin
        if (nan_a || nan_b)                      mul_res = QNAN;
        else if ((inf_a && zero_b) || (zero_a && inf_b)) mul_res = QNAN;
        else if (inf_a || inf_b)                 mul_res = {sm, EXP_MAX, 23'd0};
        else if (zero_a || zero_b)               mul_res = {sm, 31'd0};
        else if (e_mul >= 10'sd255)              mul_res = {sm, EXP_MAX, 23'd0};
        else if (e_mul <= 10'sd0)                mul_res = {sm, 31'd0};
        else                                     mul_res = {sm, e_mul[7:0], m_mul};
    end

    assign res_o = (op_i == FP_MUL) ? mul_res : add_res;

endmodule

// File: rtl/bit32_alu.sv
// Single-cycle accumulator ALU: two registers, 64-word memory,
// integer/logic/shift/load/store and FP32 add/sub/mul.
module bit32_alu
    import bit32_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic        sel,
    input  logic [5:0]  adr,
    input  logic [3:0]  opcode,
    input  logic [1:0]  bsel,
    output logic [31:0] out
);

    logic [31:0] regA_q, regB_q;
    logic [31:0] mem_q [64];

    opcode_e     op;
    lane_t       lane;
    logic [4:0]  sh;
    logic [5:0]  adr_nx;
    logic [31:0] rs, ro, md0, md1, fp_res;
    logic [31:0] rs_d, ro_d;
    logic        wr0_en, wr1_en;
    logic [31:0] wr0_data, wr1_data;
    fp_op_e      fp_op;

    assign op     = opcode_e'(opcode);
    assign lane   = lane_t'(bsel);
    assign sh     = {lane, 3'b000};
    assign adr_nx = adr + 6'd1;
    assign rs     = sel ? regB_q : regA_q;
    assign ro     = sel ? regA_q : regB_q;
    assign md0    = mem_q[adr];
    assign md1    = mem_q[adr_nx];
    assign out    = rs;

    always_comb begin
        unique case (1'b1)
            (op == FSUB): fp_op = FP_SUB;
            (op == FMUL): fp_op = FP_MUL;
            default:      fp_op = FP_ADD;
        endcase
    end

    fp32_unit u_fp (
        .a_i   (regA_q),
        .b_i   (regB_q),
        .op_i  (fp_op),
        .res_o (fp_res)
    );

    always_comb begin
        rs_d     = rs;
        ro_d     = ro;
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_data = rs;
        wr1_data = ro;
        unique case (op)
            FADD, FSUB, FMUL: rs_d = fp_res;
            AND:  rs_d = regA_q & regB_q;
            OR:   rs_d = regA_q | regB_q;
            STL:  rs_d = {31'd0, $signed(rs) < $signed(md0)};
            LDD: begin
                rs_d = md0;
                ro_d = md1;
            end
            ADDI: rs_d = rs + A;
            SLI:  rs_d = {rs[31:16], A[15:0]};
            SB: begin
                wr0_en   = 1'b1;
                wr0_data = (md0 & ~(32'h0000_00FF << sh))
                         | ({24'd0, rs[7:0]} << sh);
            end
            LB:   rs_d = {24'd0, md0[sh +: 8]};
            LW:   rs_d = md0;
            SW:   wr0_en = 1'b1;
            SLL:  rs_d = rs << A[4:0];
            SDD: begin
                wr0_en = 1'b1;
                wr1_en = 1'b1;
            end
            SRA:  rs_d = $signed(rs) >>> A[4:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regA_q <= '0;
            regB_q <= '0;
            for (int i = 0; i < 64; i++) mem_q[i] <= '0;
        end else begin
            if (sel) begin
                regB_q <= rs_d;
                regA_q <= ro_d;
            end else begin
                regA_q <= rs_d;
                regB_q <= ro_d;
            end
            if (wr0_en) mem_q[adr]    <= wr0_data;
            if (wr1_en) mem_q[adr_nx] <= wr1_data;
        end
    end

endmodule

// File: tb/tb_bit32_alu.sv
// Self-checking bench for bit32_alu: directed scenarios plus random
// integer and FP sequences against a behavioural reference model.
module tb_bit32_alu;
    import bit32_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] A;
    logic        sel;
    logic [5:0]  adr;
    logic [3:0]  opcode;
    logic [1:0]  bsel;
    logic [31:0] out;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_r [2];
    logic [31:0] m_mem [64];

    bit32_alu dut (
        .clk(clk), .rst_n(rst_n), .A(A), .sel(sel),
        .adr(adr), .opcode(opcode), .bsel(bsel), .out(out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    function automatic bit f_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 0);
    endfunction
    function automatic bit f_inf(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] == 0);
    endfunction
    function automatic bit f_zero(input logic [31:0] f);
        return f[30:23] == 8'h00;
    endfunction

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] de;
        if (f_zero(f)) return 0.0;
        de = 11'(f[30:23]) + 11'd896;
        return $bitstoreal({f[31], de, f[22:0], 29'd0});
    endfunction

    // Truncate a double (exact in all bench uses) to single precision.
    function automatic logic [31:0] r2f_tz(input real r);
        logic [63:0] d;
        int          e;
        logic [7:0]  e8;
        d  = $realtobits(r);
        e  = int'(d[62:52]) - 896;
        e8 = 8'(e);
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0)   return {d[63], 31'd0};
        return {d[63], e8, d[51:29]};
    endfunction

    function automatic logic [31:0] ref_fadd(input logic [31:0] a, input logic [31:0] b);
        real r;
        if (f_nan(a) || f_nan(b)) return QNAN;
        if (f_inf(a) && f_inf(b)) return (a[31] == b[31]) ? a : QNAN;
        if (f_inf(a)) return a;
        if (f_inf(b)) return b;
        r = f2r(a) + f2r(b);
        if (r == 0.0) return 32'h0;
        return r2f_tz(r);
    endfunction

    function automatic logic [31:0] ref_fmul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        s = a[31] ^ b[31];
        if (f_nan(a) || f_nan(b)) return QNAN;
        if ((f_inf(a) && f_zero(b)) || (f_zero(a) && f_inf(b))) return QNAN;
        if (f_inf(a) || f_inf(b)) return {s, 8'hFF, 23'd0};
        if (f_zero(a) || f_zero(b)) return {s, 31'd0};
        return r2f_tz(f2r(a) * f2r(b));
    endfunction

    task automatic model_reset();
        m_r[0] = 0;
        m_r[1] = 0;
        for (int i = 0; i < 64; i++) m_mem[i] = 0;
    endtask

    task automatic model_step(input logic [3:0] o, input logic s, input logic [31:0] a,
                              input logic [5:0] ad, input logic [1:0] bs);
        logic [31:0] rs, ro, md, md1, ra, rb;
        logic [5:0]  ad1;
        ad1 = ad + 6'd1;
        rs = m_r[s];
        ro = m_r[!s];
        ra = m_r[0];
        rb = m_r[1];
        md = m_mem[ad];
        md1 = m_mem[ad1];
        case (o)
            FADD: m_r[s] = ref_fadd(ra, rb);
            FSUB: m_r[s] = ref_fadd(ra, rb ^ 32'h8000_0000);
            FMUL: m_r[s] = ref_fmul(ra, rb);
            AND:  m_r[s] = ra & rb;
            OR:   m_r[s] = ra | rb;
            STL:  m_r[s] = ($signed(rs) < $signed(md)) ? 32'd1 : 32'd0;
            LDD: begin m_r[s] = md; m_r[!s] = md1; end
            ADDI: m_r[s] = rs + a;
            SLI:  m_r[s] = {rs[31:16], a[15:0]};
            SB:   m_mem[ad][int'(bs)*8 +: 8] = rs[7:0];
            LB:   m_r[s] = (md >> (int'(bs) * 8)) & 32'hFF;
            LW:   m_r[s] = md;
            SW:   m_mem[ad] = rs;
            SLL:  m_r[s] = rs << a[4:0];
            SDD: begin m_mem[ad] = rs; m_mem[ad1] = ro; end
            default: m_r[s] = $signed(rs) >>> a[4:0];
        endcase
    endtask

    task automatic op(input logic [3:0] o, input logic s, input logic [31:0] a,
                      input logic [5:0] ad = 6'd0, input logic [1:0] bs = 2'd0);
        @(negedge clk);
        opcode = o;
        sel = s;
        A = a;
        adr = ad;
        bsel = bs;
        model_step(o, s, a, ad, bs);
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic s, input logic [31:0] v);
        op(SLI, s, {16'd0, v[31:16]});
        op(SLL, s, 32'd16);
        op(SLI, s, {16'd0, v[15:0]});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        opcode = ADDI; A = 0; sel = 0; adr = 0; bsel = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out !== 32'h0) begin
            $display("FAIL reset_sel0: got %h want %h", out, 32'h0);
            miscompares++;
        end
        sel = 1'b1;
        #1;
        vectors++;
        if (out !== 32'h0) begin
            $display("FAIL reset_sel1: got %h want %h", out, 32'h0);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        repeat (3) op(ADDI, 1'b1, 32'd2);
        vectors++;
        if (out !== 32'h6) begin
            $display("FAIL addi_x3: got %h want %h", out, 32'h6);
            miscompares++;
        end
        op(SDD, 1'b1, 32'd0, 6'd5);
        vectors++;
        if (out !== 32'h6) begin
            $display("FAIL sdd_keeps_reg: got %h want %h", out, 32'h6);
            miscompares++;
        end
        op(LW, 1'b0, 32'd0, 6'd5);
        vectors++;
        if (out !== 32'h6) begin
            $display("FAIL sdd_m5: got %h want %h", out, 32'h6);
            miscompares++;
        end
        op(LW, 1'b0, 32'd0, 6'd6);
        vectors++;
        if (out !== 32'h0) begin
            $display("FAIL sdd_m6: got %h want %h", out, 32'h0);
            miscompares++;
        end
    endtask

    task automatic test_fp_basic();
        load(1'b0, 32'h3F80_0000);
        load(1'b1, 32'h4000_0000);
        op(FADD, 1'b0, 32'd0);
        vectors++;
        if (out !== 32'h4040_0000) begin
            $display("FAIL fadd_1p2: got %h want %h", out, 32'h4040_0000);
            miscompares++;
        end
        op(FMUL, 1'b0, 32'd0);
        vectors++;
        if (out !== 32'h40C0_0000) begin
            $display("FAIL fmul_3x2: got %h want %h", out, 32'h40C0_0000);
            miscompares++;
        end
        op(FSUB, 1'b1, 32'd0);
        vectors++;
        if (out !== 32'h4080_0000) begin
            $display("FAIL fsub_6m2: got %h want %h", out, 32'h4080_0000);
            miscompares++;
        end
    endtask

    task automatic test_mem();
        load(1'b0, 32'h1122_3344);
        op(SW, 1'b0, 32'd0, 6'd63);
        op(LB, 1'b1, 32'd0, 6'd63, 2'd2);
        vectors++;
        if (out !== 32'h0000_0022) begin
            $display("FAIL lb_lane2: got %h want %h", out, 32'h22);
            miscompares++;
        end
        load(1'b0, 32'h0000_00AB);
        op(SB, 1'b0, 32'd0, 6'd63, 2'd0);
        vectors++;
        if (out !== 32'h0000_00AB) begin
            $display("FAIL sb_keeps_reg: got %h want %h", out, 32'hAB);
            miscompares++;
        end
        op(LW, 1'b1, 32'd0, 6'd63);
        vectors++;
        if (out !== 32'h1122_33AB) begin
            $display("FAIL sb_lane0: got %h want %h", out, 32'h1122_33AB);
            miscompares++;
        end
        load(1'b1, 32'hCAFE_F00D);
        op(SW, 1'b1, 32'd0, 6'd0);
        load(1'b1, 32'h5555_AAAA);
        op(LDD, 1'b0, 32'd0, 6'd63);
        vectors++;
        if (out !== 32'h1122_33AB) begin
            $display("FAIL ldd_wrap_lo: got %h want %h", out, 32'h1122_33AB);
            miscompares++;
        end
        sel = 1'b1;
        #1;
        vectors++;
        if (out !== 32'hCAFE_F00D) begin
            $display("FAIL ldd_wrap_hi: got %h want %h", out, 32'hCAFE_F00D);
            miscompares++;
        end
    endtask

    task automatic test_shift();
        load(1'b0, 32'h8000_0000);
        op(SRA, 1'b0, 32'd2);
        vectors++;
        if (out !== 32'hE000_0000) begin
            $display("FAIL sra_neg: got %h want %h", out, 32'hE000_0000);
            miscompares++;
        end
        load(1'b0, 32'h0000_000F);
        op(SLL, 1'b0, 32'd4);
        vectors++;
        if (out !== 32'h0000_00F0) begin
            $display("FAIL sll_4: got %h want %h", out, 32'hF0);
            miscompares++;
        end
        op(SLL, 1'b0, 32'd32);
        vectors++;
        if (out !== 32'h0000_00F0) begin
            $display("FAIL sll_amt_wrap: got %h want %h", out, 32'hF0);
            miscompares++;
        end
        load(1'b1, 32'h4000_0000);
        op(SRA, 1'b1, 32'h3F);
        vectors++;
        if (out !== 32'h0) begin
            $display("FAIL sra_31: got %h want %h", out, 32'h0);
            miscompares++;
        end
        load(1'b0, 32'hFFFF_0000);
        op(SLI, 1'b0, 32'h1234);
        vectors++;
        if (out !== 32'hFFFF_1234) begin
            $display("FAIL sli: got %h want %h", out, 32'hFFFF_1234);
            miscompares++;
        end
    endtask

    task automatic test_stl();
        load(1'b1, 32'd1);
        op(SW, 1'b1, 32'd0, 6'd10);
        load(1'b0, 32'hFFFF_FFFF);
        op(STL, 1'b0, 32'd0, 6'd10);
        vectors++;
        if (out !== 32'd1) begin
            $display("FAIL stl_neg: got %h want %h", out, 32'd1);
            miscompares++;
        end
        load(1'b0, 32'd5);
        load(1'b1, 32'd5);
        op(SW, 1'b1, 32'd0, 6'd11);
        op(STL, 1'b0, 32'd0, 6'd11);
        vectors++;
        if (out !== 32'd0) begin
            $display("FAIL stl_eq: got %h want %h", out, 32'd0);
            miscompares++;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  o;
        logic [31:0] want;
    } fp_vec_t;

    task automatic test_fp_edges();
        fp_vec_t v [13];
        v[0]  = '{32'h3F80_0000, 32'hBF80_0000, FADD, 32'h0000_0000};
        v[1]  = '{32'h7F7F_FFFF, 32'h4000_0000, FMUL, 32'h7F80_0000};
        v[2]  = '{32'h7FC1_2345, 32'h3F80_0000, FADD, QNAN};
        v[3]  = '{32'h3F80_0000, 32'h7F80_0001, FMUL, QNAN};
        v[4]  = '{32'h7F80_0000, 32'h7F80_0000, FSUB, QNAN};
        v[5]  = '{32'h0000_0000, 32'hFF80_0000, FMUL, QNAN};
        v[6]  = '{32'h0000_0001, 32'h3F80_0000, FMUL, 32'h0000_0000};
        v[7]  = '{32'h0080_0000, 32'h3F00_0000, FMUL, 32'h0000_0000};
        v[8]  = '{32'h3F80_0000, 32'h0080_0000, FSUB, 32'h3F7F_FFFF};
        v[9]  = '{32'h3F80_0000, 32'h0080_0000, FADD, 32'h3F80_0000};
        v[10] = '{32'h8000_0000, 32'h8000_0000, FADD, 32'h0000_0000};
        v[11] = '{32'h3FFF_FFFF, 32'h3FFF_FFFF, FMUL, 32'h407F_FFFE};
        v[12] = '{32'h7F00_0000, 32'h7F00_0000, FADD, 32'h7F80_0000};
        for (int i = 0; i < 13; i++) begin
            load(1'b0, v[i].a);
            load(1'b1, v[i].b);
            op(v[i].o, 1'b0, 32'd0);
            vectors++;
            if (out !== v[i].want) begin
                $display("FAIL fp_edge_%0d: a=%h b=%h got %h want %h",
                         i, v[i].a, v[i].b, out, v[i].want);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid();
        load(1'b0, 32'h1234_5678);
        op(SW, 1'b0, 32'd0, 6'd20);
        @(negedge clk);
        opcode = ADDI;
        sel = 1'b0;
        A = 32'd1;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out !== 32'h0) begin
            $display("FAIL reset_async: got %h want %h", out, 32'h0);
            miscompares++;
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out !== 32'h0) begin
            $display("FAIL reset_discard: got %h want %h", out, 32'h0);
            miscompares++;
        end
        @(negedge clk);
        A = 32'd0;
        model_reset();
        rst_n = 1'b1;
        op(LW, 1'b1, 32'd0, 6'd20);
        vectors++;
        if (out !== 32'h0) begin
            $display("FAIL reset_mem: got %h want %h", out, 32'h0);
            miscompares++;
        end
    endtask

    task automatic test_random_int();
        logic [3:0]  o;
        logic        s;
        logic [5:0]  ad;
        load(1'b0, $urandom);
        load(1'b1, $urandom);
        for (int i = 0; i < 400; i++) begin
            o  = 4'(3 + $urandom_range(0, 12));
            s  = 1'($urandom_range(0, 1));
            ad = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
            op(o, s, $urandom, ad, 2'($urandom_range(0, 3)));
            vectors++;
            if (out !== m_r[s]) begin
                $display("FAIL rand_int_%0d: op=%0d got %h want %h", i, o, out, m_r[s]);
                miscompares++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            op(LW, 1'b0, 32'd0, 6'(i));
            vectors++;
            if (out !== m_r[0]) begin
                $display("FAIL rand_mem_%0d: got %h want %h", i, out, m_r[0]);
                miscompares++;
            end
        end
    endtask

    function automatic logic [31:0] rnd_float();
        logic [7:0] e;
        e = 8'(112 + $urandom_range(0, 28));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic test_random_fp();
        logic [31:0] a, b;
        logic [3:0]  o;
        logic        s;
        for (int i = 0; i < 80; i++) begin
            a = rnd_float();
            b = rnd_float();
            load(1'b0, a);
            load(1'b1, b);
            o = 4'($urandom_range(0, 2));
            s = 1'($urandom_range(0, 1));
            op(o, s, 32'd0);
            vectors++;
            if (out !== m_r[s]) begin
                $display("FAIL rand_fp_%0d: op=%0d a=%h b=%h got %h want %h",
                         i, o, a, b, out, m_r[s]);
                miscompares++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_fp_basic();
        test_mem();
        test_shift();
        test_stl();
        test_fp_edges();
        test_reset_mid();
        test_random_int();
        test_random_fp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
